// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Groups the byte-write handshake, FIFO status flags and serial
//            line outputs of uart_tx_fifo into one bundle.
// Ports    : master - byte producer: drives en/data_in/data_valid and
//                     observes full/empty/overflow/q/active/done
//            slave  - uart_tx_fifo: the mirror image of master
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              q;
    logic              active;
    logic              done;

    modport master (
        output en, data_in, data_valid,
        input  full, empty, overflow, q, active, done
    );

    modport slave (
        input  en, data_in, data_valid,
        output full, empty, overflow, q, active, done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter with a small input FIFO. Bytes written with
//            data_valid are queued and serialised LSB first as
//            start / data / [even parity] / stop frames on q.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - uart_tx_fifo_if.slave: en, data_in, data_valid (in);
//                   full, empty, overflow, q, active, done (out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);

    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    // Shifter / FSM
    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [c_bit_w-1:0]  r_bit_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parity;
    logic                r_q;
    logic                r_active;
    logic                r_done;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_baud_tick;
    logic w_can_start;

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push      = bus.data_valid && !w_full;
    assign w_baud_tick = (r_baud == c_baud_last);
    assign w_can_start = bus.en && !w_empty;
    // Pop from IDLE, or at the end of a stop bit to chain frames with no gap.
    assign w_pop       = w_can_start &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_tick));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.data_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_q       <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Line outputs are registered decodes of the current state, so
            // q, active and done trail the state by one cycle together and
            // stay mutually aligned.
            r_active <= (r_state != ST_IDLE);
            r_done   <= (r_state == ST_STOP) && w_baud_tick;
            case (r_state)
                ST_START:  r_q <= 1'b0;
                ST_DATA:   r_q <= r_shift[0];
                ST_PARITY: r_q <= r_parity;
                default:   r_q <= 1'b1;
            endcase

            if (r_state == ST_IDLE || w_baud_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_parity <= ^r_mem[r_rd_ptr];
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_baud_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == c_bit_last) begin
                            r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_baud_tick) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_baud_tick) begin
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd_ptr];
                            r_parity <= ^r_mem[r_rd_ptr];
                            r_state  <= ST_START;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.overflow = r_overflow;
    assign bus.q        = r_q;
    assign bus.active   = r_active;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo. Two instances
//            share clk/rst: u_dut0 without parity, u_dut1 with even parity.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_fifo_if #(.DATA_W(8)) bus0 ();
    uart_tx_fifo_if #(.DATA_W(8)) bus1 ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(8), .PARITY_EN(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(8), .PARITY_EN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic get_q(input bit p);
        return p ? bus1.q : bus0.q;
    endfunction
    function automatic logic get_active(input bit p);
        return p ? bus1.active : bus0.active;
    endfunction
    function automatic logic get_done(input bit p);
        return p ? bus1.done : bus0.done;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input bit p, input logic v);
        if (p) bus1.en = v;
        else   bus0.en = v;
    endtask

    // Present one byte for one clock; caller ends the burst with end_write.
    task automatic write_byte(input bit p, input logic [7:0] b);
        if (p) begin bus1.data_valid = 1'b1; bus1.data_in = b; end
        else   begin bus0.data_valid = 1'b1; bus0.data_in = b; end
        @(negedge clk);
    endtask

    task automatic end_write(input bit p);
        if (p) bus1.data_valid = 1'b0;
        else   bus0.data_valid = 1'b0;
    endtask

    task automatic wait_fall(input bit p, input int max, input string tag);
        int n = 0;
        while (get_q(p) !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start bit within bound"}, get_q(p), 1'b0);
    endtask

    // Called at the negedge of the first start-bit cycle; checks every cycle
    // of the frame and returns at the negedge of the cycle after it.
    task automatic walk_frame(input bit p, input logic [7:0] b, input logic pbit,
                              input int drop_at, input string tag);
        int   len = (p ? 11 : 10) * CPB;
        logic exp_q;
        for (int c = 0; c < len; c++) begin
            int k = c / CPB;
            if (k == 0)            exp_q = 1'b0;
            else if (k <= 8)       exp_q = b[k-1];
            else if (p && k == 9)  exp_q = pbit;
            else                   exp_q = 1'b1;
            check($sformatf("%s q c%0d", tag, c), get_q(p), exp_q);
            check($sformatf("%s active c%0d", tag, c), get_active(p), 1'b1);
            check($sformatf("%s done c%0d", tag, c), get_done(p), (c == len - 1));
            if (c == drop_at) set_en(p, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input bit p, input string tag);
        check({tag, " q idle"}, get_q(p), 1'b1);
        check({tag, " active idle"}, get_active(p), 1'b0);
        check({tag, " done idle"}, get_done(p), 1'b0);
    endtask

    initial begin
        int falls;
        rst = 1'b1;
        bus0.en = 1'b0; bus0.data_valid = 1'b0; bus0.data_in = 8'h00;
        bus1.en = 1'b0; bus1.data_valid = 1'b0; bus1.data_in = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst q", bus0.q, 1'b1);
        check("rst active", bus0.active, 1'b0);
        check("rst done", bus0.done, 1'b0);
        check("rst overflow", bus0.overflow, 1'b0);
        check("rst full", bus0.full, 1'b0);
        check("rst empty", bus0.empty, 1'b1);
        check("rst q par", bus1.q, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5: pop one edge after the write, q falls one edge later
        bus0.en = 1'b1;
        write_byte(0, 8'hA5);
        end_write(0);
        check("t1 empty after write", bus0.empty, 1'b0);
        check("t1 q before pop", bus0.q, 1'b1);
        @(negedge clk);
        check("t1 q after pop", bus0.q, 1'b1);
        check("t1 active after pop", bus0.active, 1'b0);
        check("t1 empty after pop", bus0.empty, 1'b1);
        @(negedge clk);
        walk_frame(0, 8'hA5, 1'b0, -1, "t1");
        check_idle(0, "t1 end");
        check("t1 empty end", bus0.empty, 1'b1);

        // Three bytes back to back, no idle between frames
        write_byte(0, 8'h01);
        write_byte(0, 8'h02);
        write_byte(0, 8'h03);
        end_write(0);
        wait_fall(0, 5, "t2");
        walk_frame(0, 8'h01, 1'b0, -1, "t2 f1");
        walk_frame(0, 8'h02, 1'b0, -1, "t2 f2");
        walk_frame(0, 8'h03, 1'b0, -1, "t2 f3");
        check_idle(0, "t2 end");
        check("t2 empty end", bus0.empty, 1'b1);

        // Fill with en low, ninth write overflows and is dropped
        bus0.en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            write_byte(0, 8'(i));
            if (i == 7) begin
                check("t3 full at 8", bus0.full, 1'b1);
                check("t3 no overflow at 8", bus0.overflow, 1'b0);
            end
        end
        end_write(0);
        check("t3 overflow", bus0.overflow, 1'b1);
        check("t3 full", bus0.full, 1'b1);
        repeat (3) @(negedge clk);
        check_idle(0, "t3 held by en");
        bus0.en = 1'b1;
        wait_fall(0, 5, "t3");
        for (int i = 0; i < 8; i++) begin
            walk_frame(0, 8'(i), 1'b0, -1, $sformatf("t3 f%0d", i));
        end
        check_idle(0, "t3 end");
        check("t3 empty end", bus0.empty, 1'b1);
        check("t3 overflow sticky", bus0.overflow, 1'b1);

        // Even parity instance
        bus1.en = 1'b1;
        write_byte(1, 8'h07);
        end_write(1);
        wait_fall(1, 5, "t4a");
        walk_frame(1, 8'h07, 1'b1, -1, "t4a");
        check_idle(1, "t4a end");
        write_byte(1, 8'h03);
        end_write(1);
        wait_fall(1, 5, "t4b");
        walk_frame(1, 8'h03, 1'b0, -1, "t4b");
        check_idle(1, "t4b end");

        // Reset during data bit 3 with two bytes still queued
        check("t5 overflow before rst", bus0.overflow, 1'b1);
        write_byte(0, 8'h11);
        write_byte(0, 8'h22);
        write_byte(0, 8'h33);
        end_write(0);
        wait_fall(0, 5, "t5");
        repeat (17) @(negedge clk);
        check("t5 q in bit3", bus0.q, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5 q async", bus0.q, 1'b1);
        check("t5 active async", bus0.active, 1'b0);
        check("t5 empty async", bus0.empty, 1'b1);
        check("t5 overflow cleared", bus0.overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        falls = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus0.q !== 1'b1 || bus0.active !== 1'b0) falls++;
        end
        check("t5 no frame after rst", 32'(falls), 32'd0);
        check("t5 empty after rst", bus0.empty, 1'b1);

        // en dropped mid-data of first of two frames
        write_byte(0, 8'h3C);
        write_byte(0, 8'hC3);
        end_write(0);
        wait_fall(0, 5, "t6a");
        walk_frame(0, 8'h3C, 1'b0, 20, "t6a");
        check_idle(0, "t6 held");
        check("t6 second still queued", bus0.empty, 1'b0);
        falls = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus0.q !== 1'b1) falls++;
        end
        check("t6 no start while en low", 32'(falls), 32'd0);
        bus0.en = 1'b1;
        @(negedge clk);
        check("t6 q after pop", bus0.q, 1'b1);
        check("t6 empty after pop", bus0.empty, 1'b1);
        @(negedge clk);
        walk_frame(0, 8'hC3, 1'b0, -1, "t6b");
        check_idle(0, "t6 end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
